// File: rtl/uip_meas_sched.sv
// uip_meas_sched: shares the single analog measurement path (ua pad plus the
// external instrument) among N_IP analog micro-IPs. Requests are arbitrated
// round-robin. Each grant runs through a break-before-make gap, an enable and
// settle phase, a measure window and a release cycle. Completion is reported
// as done, and early termination as abort.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req[N_IP]            per-IP measurement request (level, held until done/abort)
//   mask[N_IP]           per-IP disable; a masked IP is never granted
//   settle_cyc, meas_cyc settle / measure durations, sampled at grant (0 acts as 1)
//   sel[N_IP]            one-hot analog pass-gate select, zero when disconnected
//   ip_en                bias/enable for the granted IP
//   meas_en              high during the measure window
//   gnt_id               index of the current or last granted IP
//   busy                 high whenever the scheduler is not idle
//   done, abort          one-cycle completion / early-termination pulses
module uip_meas_sched #(
    parameter int unsigned N_IP    = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned BBM_CYC = 2,
    localparam int unsigned ID_W   = $clog2(N_IP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IP-1:0]   req,
    input  logic [N_IP-1:0]   mask,
    input  logic [CNT_W-1:0]  settle_cyc,
    input  logic [CNT_W-1:0]  meas_cyc,
    output logic [N_IP-1:0]   sel,
    output logic              ip_en,
    output logic              meas_en,
    output logic [ID_W-1:0]   gnt_id,
    output logic              busy,
    output logic              done,
    output logic              abort
);

    typedef enum logic [2:0] {
        IDLE,
        BBM,
        SETTLE,
        MEASURE,
        RELEASE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    s_q, s_d;
    logic [CNT_W-1:0]    m_q, m_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [N_IP-1:0]     sel_q, sel_d;
    logic                ip_en_q, ip_en_d;
    logic                meas_en_q, meas_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;

    logic [N_IP-1:0]     elig_c;
    logic [ID_W:0]       pick_c;
    logic                lost_c;
    logic                abort_c;
    logic                conn_c;

    // Round-robin pick: first eligible slot scanning upward from p+1 with wrap.
    // Result MSB flags that a slot was found.
    function automatic logic [ID_W:0] rr_pick(input logic [N_IP-1:0] e,
                                              input logic [ID_W-1:0] p);
        logic [ID_W:0] r;
        int unsigned   idx;
        r = '0;
        for (int unsigned i = 1; i <= N_IP; i++) begin
            idx = 32'(p) + i;
            if (idx >= N_IP) begin
                idx = idx - N_IP;
            end
            if (!r[ID_W] && e[ID_W'(idx)]) begin
                r = {1'b1, ID_W'(idx)};
            end
        end
        return r;
    endfunction

    assign elig_c = req & ~mask;
    assign pick_c = rr_pick(elig_c, ptr_q);
    // The granted IP withdrew or got masked: terminate the grant early.
    assign lost_c = !req[gnt_id_q] || mask[gnt_id_q];

    // Next-state, counters and registered-output inputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        m_d       = m_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        abort_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_c[ID_W]) begin
                    gnt_id_d = pick_c[ID_W-1:0];
                    s_d      = (settle_cyc == '0) ? CNT_W'(1) : settle_cyc;
                    m_d      = (meas_cyc == '0) ? CNT_W'(1) : meas_cyc;
                    cnt_d    = CNT_W'(BBM_CYC - 1);
                    state_d  = BBM;
                end
            end
            // Requests are not re-checked here; the grant is kept.
            BBM: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = s_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (lost_c) begin
                    state_d = RELEASE;
                    abort_c = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = MEASURE;
                    cnt_d   = m_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MEASURE: begin
                if (lost_c) begin
                    state_d = RELEASE;
                    abort_c = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                ptr_d   = gnt_id_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        conn_c    = (state_d == SETTLE) || (state_d == MEASURE);
        sel_d     = conn_c ? (N_IP'(1) << gnt_id_d) : '0;
        ip_en_d   = conn_c;
        meas_en_d = (state_d == MEASURE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == RELEASE) && !abort_c;
        abort_d   = (state_d == RELEASE) && abort_c;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_q       <= CNT_W'(1);
            m_q       <= CNT_W'(1);
            gnt_id_q  <= '0;
            ptr_q     <= ID_W'(N_IP - 1);
            sel_q     <= '0;
            ip_en_q   <= 1'b0;
            meas_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            m_q       <= m_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            ip_en_q   <= ip_en_d;
            meas_en_q <= meas_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign sel     = sel_q;
    assign ip_en   = ip_en_q;
    assign meas_en = meas_en_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign abort   = abort_q;

endmodule

// File: tb/tb_uip_meas_sched.sv
// Testbench for uip_meas_sched: scoreboard of expected grant completions
// (slot, abort/done, connected cycles, measure cycles) checked by a negedge
// monitor, plus cycle-exact checks of the single-grant, abort and reset cases.
module tb_uip_meas_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned B  = 2;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  mask;
    logic [CW-1:0] settle_cyc;
    logic [CW-1:0] meas_cyc;
    logic [N-1:0]  sel;
    logic          ip_en;
    logic          meas_en;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          done;
    logic          abort;

    uip_meas_sched #(.N_IP(N), .CNT_W(CW), .BBM_CYC(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mask       (mask),
        .settle_cyc (settle_cyc),
        .meas_cyc   (meas_cyc),
        .sel        (sel),
        .ip_en      (ip_en),
        .meas_en    (meas_en),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .done       (done),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit ab;
        int sel_n;
        int meas_n;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_grant(input int id, input bit ab, input int sn, input int mn);
        exp_t e;
        e.id = id; e.ab = ab; e.sel_n = sn; e.meas_n = mn;
        sb_q.push_back(e);
    endtask

    // Monitor: invariants every cycle, per-grant statistics, scoreboard pops.
    int           sel_n = 0;
    int           meas_n = 0;
    int           gap = 0;
    bit           seen_sel = 1'b0;
    logic [N-1:0] last_sel = '0;

    always @(negedge clk) begin
        exp_t e;
        logic inv_ok;
        inv_ok = ($countones(sel) <= 1) && (!meas_en || ip_en) && (!ip_en || sel != '0)
                 && (sel == '0 || sel == (N'(1) << gnt_id)) && !(done && abort);
        chk("invariant", 32'(inv_ok), 32'd1);

        if (sel != '0) begin
            if (seen_sel && gap > 0) chk("bbm_gap", 32'(gap >= int'(1 + B)), 32'd1);
            gap = 0;
            seen_sel = 1'b1;
        end else begin
            gap++;
        end

        if (busy) begin
            if (sel != '0) begin
                sel_n++;
                last_sel = sel;
            end
            if (meas_en) meas_n++;
        end

        if (done || abort) begin
            chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("gnt_id", 32'(gnt_id), 32'(e.id));
                chk("abort_kind", 32'(abort), 32'(e.ab));
                chk("sel_cycles", 32'(sel_n), 32'(e.sel_n));
                chk("meas_cycles", 32'(meas_n), 32'(e.meas_n));
                if (sel_n > 0) chk("sel_value", 32'(last_sel), 32'(N'(1) << e.id));
            end
            sel_n = 0;
            meas_n = 0;
        end else if (!busy) begin
            sel_n = 0;
            meas_n = 0;
        end
    end

    task automatic do_reset();
        req = '0;
        mask = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Wait for n done/abort pulses; cyc returns the cycle of the last one.
    task automatic wait_pulses(input int n, input int budget, output int cyc);
        int seen = 0;
        cyc = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done || abort) seen++;
        end
        chk("pulse_count", 32'(seen), 32'(n));
    endtask

    task automatic wait_meas(input int budget);
        int c = 0;
        while (!meas_en && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("meas_seen", 32'(meas_en), 32'd1);
    endtask

    task automatic wait_sel(input int budget);
        int c = 0;
        while (sel == '0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("sel_seen", 32'(sel != '0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int idle_sel;

        // Reset then idle.
        rst = 1'b1; req = '0; mask = '0; settle_cyc = '0; meas_cyc = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_ip_en", 32'(ip_en), 32'd0);
        chk("rst_meas_en", 32'(meas_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        rst = 1'b0;
        idle_sel = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sel != '0 || busy) idle_sel++;
        end
        chk("idle_quiet", 32'(idle_sel), 32'd0);

        // Single grant, cycle-exact.
        req = 4'b0010; settle_cyc = 8'd3; meas_cyc = 8'd5;
        expect_grant(1, 1'b0, 8, 5);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("sg_sel_c%0d", k), 32'(sel), (k >= 3 && k <= 10) ? 32'h2 : 32'h0);
            chk($sformatf("sg_ip_en_c%0d", k), 32'(ip_en), 32'(k >= 3 && k <= 10));
            chk($sformatf("sg_meas_c%0d", k), 32'(meas_en), 32'(k >= 6 && k <= 10));
            chk($sformatf("sg_done_c%0d", k), 32'(done), 32'(k == 11));
            chk($sformatf("sg_busy_c%0d", k), 32'(busy), 32'(k >= 1 && k <= 11));
            if (k == 11) begin
                chk("sg_gnt_id", 32'(gnt_id), 32'd1);
                req = '0;
            end
        end

        // Round-robin over all four slots.
        do_reset();
        req = 4'b1111; settle_cyc = 8'd1; meas_cyc = 8'd1;
        expect_grant(0, 1'b0, 2, 1);
        expect_grant(1, 1'b0, 2, 1);
        expect_grant(2, 1'b0, 2, 1);
        expect_grant(3, 1'b0, 2, 1);
        expect_grant(0, 1'b0, 2, 1);
        wait_pulses(5, 200, cyc);
        req = '0;
        @(negedge clk);

        // Masked slots are skipped.
        do_reset();
        req = 4'b1111; mask = 4'b0101; settle_cyc = 8'd1; meas_cyc = 8'd1;
        expect_grant(1, 1'b0, 2, 1);
        expect_grant(3, 1'b0, 2, 1);
        expect_grant(1, 1'b0, 2, 1);
        wait_pulses(3, 200, cyc);
        req = '0;
        @(negedge clk);

        // Mask the granted slot mid-measure.
        mask = '0; req = 4'b1000; settle_cyc = 8'd2; meas_cyc = 8'd10;
        expect_grant(3, 1'b1, 4, 2);
        wait_meas(50);
        @(negedge clk);
        mask = 4'b1000;
        @(negedge clk);
        chk("mk_abort", 32'(abort), 32'd1);
        chk("mk_done", 32'(done), 32'd0);
        chk("mk_sel", 32'(sel), 32'd0);
        chk("mk_ip_en", 32'(ip_en), 32'd0);
        req = '0; mask = '0;
        @(negedge clk);
        chk("mk_idle", 32'(busy), 32'd0);

        // Withdraw request in the second settle cycle.
        do_reset();
        req = 4'b0100; settle_cyc = 8'd5; meas_cyc = 8'd3;
        expect_grant(2, 1'b1, 2, 0);
        wait_sel(50);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("wd_abort", 32'(abort), 32'd1);
        chk("wd_done", 32'(done), 32'd0);
        chk("wd_sel", 32'(sel), 32'd0);
        @(negedge clk);

        // Reset mid-measure: outputs drop, no pulse, pointer back to slot 0 priority.
        do_reset();
        req = 4'b0010; settle_cyc = 8'd1; meas_cyc = 8'd1;
        expect_grant(1, 1'b0, 2, 1);
        wait_pulses(1, 50, cyc);
        req = '0;
        @(negedge clk);
        req = 4'b1000; settle_cyc = 8'd1; meas_cyc = 8'd20;
        wait_meas(50);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_sel", 32'(sel), 32'd0);
        chk("rm_ip_en", 32'(ip_en), 32'd0);
        chk("rm_meas_en", 32'(meas_en), 32'd0);
        chk("rm_pulse", 32'(done | abort), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        rst = 1'b0; req = 4'b1111; settle_cyc = 8'd1; meas_cyc = 8'd1;
        expect_grant(0, 1'b0, 2, 1);
        wait_pulses(1, 50, cyc);
        req = '0;
        @(negedge clk);

        // Zero counts behave as one cycle each.
        req = 4'b0001; settle_cyc = 8'd0; meas_cyc = 8'd0;
        expect_grant(0, 1'b0, 2, 1);
        wait_pulses(1, 50, cyc);
        chk("zero_latency", 32'(cyc), 32'(1 + B + 1 + 1));
        req = '0;
        @(negedge clk);

        // Maximum counts, no wrap.
        req = 4'b0001; settle_cyc = 8'd255; meas_cyc = 8'd255;
        expect_grant(0, 1'b0, 510, 255);
        wait_pulses(1, 700, cyc);
        chk("max_latency", 32'(cyc), 32'(1 + B + 255 + 255));
        req = '0;

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
